rib_dma: RTL and testbench
==========================

RIB_DMA -- requirements
Module: rib_dma

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the transfer-length register in 32-bit words.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 i_clk  in  1  sole clock, rising edge.
REQ-004 i_rst  in  1  asynchronous active-high reset.
REQ-005 Config RIB responder: i_ribs_addr in 32, i_ribs_wrcs in 1 (1=write), i_ribs_mask in 4, i_ribs_wdata in 32, o_ribs_rdata out 32, i_ribs_req in 1, o_ribs_gnt out 1, o_ribs_rsp out 1, i_ribs_rdy in 1.
REQ-006 Data RIB initiator: o_ribm_addr out 32, o_ribm_wrcs out 1, o_ribm_mask out 4, o_ribm_wdata out 32, i_ribm_rdata in 32, o_ribm_req out 1, i_ribm_gnt in 1, i_ribm_rsp in 1, o_ribm_rdy out 1.
REQ-007 o_irq  out  1  one-cycle pulse on transfer completion.

Function
REQ-008 RIB request beat SHALL occur on a rising edge with req&gnt high; response beat on a rising edge with rsp&rdy high; at most one transaction outstanding per port.
REQ-009 Responder SHALL drive o_ribs_gnt = i_ribs_req whenever no response is pending, else 0.
REQ-010 Responder SHALL assert o_ribs_rsp the cycle after a request beat and hold it with stable o_ribs_rdata until the response beat.
REQ-011 Register map (addr[3:0]): 0x0 SRC, 0x4 DST, 0x8 LEN (LEN_W bits, upper read 0), 0xC CTRL; other offsets read 0, writes ignored.
REQ-012 CTRL read: bit0 0, bit1 BUSY, bit2 DONE (sticky); write: bit0=1 START, bit2=1 clears DONE.
REQ-013 Register writes SHALL honour i_ribs_mask per byte; SRC/DST/LEN writes while BUSY SHALL be ignored.
REQ-014 FSM states IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP, FIN.
REQ-015 IDLE: START with LEN!=0 -> RD_REQ, BUSY=1, internal counters load SRC/DST/LEN; START with LEN=0 -> FIN with no bus traffic; START while BUSY ignored.
REQ-016 RD_REQ: o_ribm_req=1, wrcs=0, addr=cur_src, mask=4'hf; on gnt -> RD_RSP.
REQ-017 RD_RSP: o_ribm_rdy=1; on rsp capture i_ribm_rdata into data buffer -> WR_REQ.
REQ-018 WR_REQ: req=1, wrcs=1, addr=cur_dst, wdata=buffer, mask=4'hf; on gnt -> WR_RSP.
REQ-019 WR_RSP: rdy=1; on rsp: cur_src+=4, cur_dst+=4 (modulo 2^32 wrap), remaining-=1; remaining reaching 0 -> FIN, else RD_REQ.
REQ-020 FIN (one cycle): BUSY=0, DONE=1, o_irq=1 -> IDLE.
REQ-021 Simultaneous DONE-clear write and FIN SHALL leave DONE=1 (set wins).
REQ-022 Initiator outputs SHALL be stable while req is high and no gnt; o_ribm_req and o_ribm_rdy SHALL be 0 in IDLE/FIN.
REQ-023 SRC/DST/LEN registers SHALL not change during a transfer; progress is held in separate counters.

Reset
REQ-024 On i_rst: FSM=IDLE; SRC, DST, LEN, counters, buffer, BUSY, DONE = 0.
REQ-025 On i_rst: o_ribs_gnt/rsp, o_ribm_req/rdy/wrcs, o_irq = 0; o_ribs_rdata, o_ribm_addr/wdata = 0; o_ribm_mask = 4'h0.
REQ-026 Reset mid-transfer SHALL abandon the transfer immediately with no FIN/irq; outstanding bus transaction is dropped.

Structure
REQ-027 Package rib_dma_pkg SHALL hold register offsets, CTRL bit positions and FSM state encoding.
REQ-028 Config register file and responder logic SHALL be sub-module rib_dma_regs; FSM and initiator in rib_dma.

Verification
REQ-029 SRC=0x100, DST=0x200, LEN=4, START; memory model gnt/rsp immediate -> 4 reads 0x100..0x10C, 4 writes 0x200..0x20C with matching data, one o_irq, CTRL reads 0x4.
REQ-030 Same with random gnt/rsp delays 0-5 cycles -> identical transaction sequence, outputs stable while stalled.
REQ-031 LEN=0, START -> no o_ribm_req, o_irq next-but-one cycle, DONE=1.
REQ-032 SRC=0xFFFFFFFC, LEN=2 -> second read address 0x00000000.
REQ-033 Write LEN=9 and START during BUSY -> ignored; transfer completes with original LEN.
REQ-034 Assert i_rst during WR_REQ -> all outputs 0 same cycle, no o_irq, CTRL reads 0 afterwards.

Source files
------------

// File: rtl/rib_dma_pkg.sv
// Shared definitions for the RIB DMA: register offsets, CTRL bit positions,
// FSM state encoding and the byte-mask merge helper.
package rib_dma_pkg;

    localparam logic [3:0] REG_SRC  = 4'h0;
    localparam logic [3:0] REG_DST  = 4'h4;
    localparam logic [3:0] REG_LEN  = 4'h8;
    localparam logic [3:0] REG_CTRL = 4'hC;

    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_DONE  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_RSP,
        ST_WR_REQ,
        ST_WR_RSP,
        ST_FIN
    } state_e;

    function automatic logic [31:0] apply_mask(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  mask);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/rib_dma_regs.sv
// Config register file behind the RIB responder port. START leaves as a
// one-cycle registered pulse; DONE is sticky and set by the FSM's FIN cycle.
module rib_dma_regs
    import rib_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_ribs_addr,
    input  logic             i_ribs_wrcs,
    input  logic [3:0]       i_ribs_mask,
    input  logic [31:0]      i_ribs_wdata,
    output logic [31:0]      o_ribs_rdata,
    input  logic             i_ribs_req,
    output logic             o_ribs_gnt,
    output logic             o_ribs_rsp,
    input  logic             i_ribs_rdy,
    input  logic             busy_i,
    input  logic             fin_i,
    output logic [31:0]      src_o,
    output logic [31:0]      dst_o,
    output logic [LEN_W-1:0] len_o,
    output logic             start_o
);

    logic             rsp_q;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      src_q, dst_q;
    logic [LEN_W-1:0] len_q;
    logic             done_q, start_q;
    logic             req_beat, wr_beat, ctrl_wr;
    logic [3:0]       offs;
    logic             addr_unused;

    assign offs        = i_ribs_addr[3:0];
    assign addr_unused = ^i_ribs_addr[31:4];

    assign o_ribs_gnt = i_ribs_req & ~rsp_q;
    assign req_beat   = i_ribs_req & o_ribs_gnt;
    assign wr_beat    = req_beat & i_ribs_wrcs;
    // CTRL command bits all live in byte 0, so only mask[0] can enable them.
    assign ctrl_wr    = wr_beat && (offs == REG_CTRL) && i_ribs_mask[0];

    always_comb begin
        rdata_d = '0;
        case (offs)
            REG_SRC:  rdata_d = src_q;
            REG_DST:  rdata_d = dst_q;
            REG_LEN:  rdata_d = 32'(len_q);
            REG_CTRL: begin
                rdata_d[CTRL_BUSY] = busy_i;
                rdata_d[CTRL_DONE] = done_q;
            end
            default:  rdata_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rsp_q   <= 1'b0;
            rdata_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            if (req_beat)                rsp_q <= 1'b1;
            else if (rsp_q & i_ribs_rdy) rsp_q <= 1'b0;

            if (req_beat && !i_ribs_wrcs) rdata_q <= rdata_d;

            // Programmed values are frozen while a transfer runs.
            if (wr_beat && !busy_i) begin
                case (offs)
                    REG_SRC: src_q <= apply_mask(src_q, i_ribs_wdata, i_ribs_mask);
                    REG_DST: dst_q <= apply_mask(dst_q, i_ribs_wdata, i_ribs_mask);
                    REG_LEN: len_q <= LEN_W'(apply_mask(32'(len_q), i_ribs_wdata, i_ribs_mask));
                    default: ;
                endcase
            end

            start_q <= ctrl_wr & i_ribs_wdata[CTRL_START];

            if (fin_i)                                 done_q <= 1'b1;
            else if (ctrl_wr & i_ribs_wdata[CTRL_DONE]) done_q <= 1'b0;
        end
    end

    assign o_ribs_rsp   = rsp_q;
    assign o_ribs_rdata = rdata_q;
    assign src_o        = src_q;
    assign dst_o        = dst_q;
    assign len_o        = len_q;
    assign start_o      = start_q;

endmodule

// File: rtl/rib_dma.sv
// Word-copy DMA: one read then one write per 32-bit word on the RIB initiator,
// configured through rib_dma_regs. Progress lives in private counters.
module rib_dma
    import rib_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_ribs_addr,
    input  logic        i_ribs_wrcs,
    input  logic [3:0]  i_ribs_mask,
    input  logic [31:0] i_ribs_wdata,
    output logic [31:0] o_ribs_rdata,
    input  logic        i_ribs_req,
    output logic        o_ribs_gnt,
    output logic        o_ribs_rsp,
    input  logic        i_ribs_rdy,
    output logic [31:0] o_ribm_addr,
    output logic        o_ribm_wrcs,
    output logic [3:0]  o_ribm_mask,
    output logic [31:0] o_ribm_wdata,
    input  logic [31:0] i_ribm_rdata,
    output logic        o_ribm_req,
    input  logic        i_ribm_gnt,
    input  logic        i_ribm_rsp,
    output logic        o_ribm_rdy,
    output logic        o_irq
);

    state_e           state_q, state_d;
    logic [31:0]      cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
    logic [31:0]      buf_q, buf_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [31:0]      src, dst;
    logic [LEN_W-1:0] len;
    logic             start, busy, fin;

    assign busy = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign fin  = (state_q == ST_FIN);

    rib_dma_regs #(.LEN_W(LEN_W)) u_regs (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ribs_addr  (i_ribs_addr),
        .i_ribs_wrcs  (i_ribs_wrcs),
        .i_ribs_mask  (i_ribs_mask),
        .i_ribs_wdata (i_ribs_wdata),
        .o_ribs_rdata (o_ribs_rdata),
        .i_ribs_req   (i_ribs_req),
        .o_ribs_gnt   (o_ribs_gnt),
        .o_ribs_rsp   (o_ribs_rsp),
        .i_ribs_rdy   (i_ribs_rdy),
        .busy_i       (busy),
        .fin_i        (fin),
        .src_o        (src),
        .dst_o        (dst),
        .len_o        (len),
        .start_o      (start)
    );

    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        cur_dst_d   = cur_dst_q;
        buf_d       = buf_q;
        rem_d       = rem_q;
        o_ribm_req  = 1'b0;
        o_ribm_wrcs = 1'b0;
        o_ribm_addr = '0;
        o_ribm_mask = 4'h0;
        o_ribm_rdy  = 1'b0;
        o_irq       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d   = ST_RD_REQ;
                        cur_src_d = src;
                        cur_dst_d = dst;
                        rem_d     = len;
                    end
                end
            end
            ST_RD_REQ: begin
                o_ribm_req  = 1'b1;
                o_ribm_addr = cur_src_q;
                o_ribm_mask = 4'hf;
                if (i_ribm_gnt) state_d = ST_RD_RSP;
            end
            ST_RD_RSP: begin
                o_ribm_rdy = 1'b1;
                if (i_ribm_rsp) begin
                    buf_d   = i_ribm_rdata;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                o_ribm_req  = 1'b1;
                o_ribm_wrcs = 1'b1;
                o_ribm_addr = cur_dst_q;
                o_ribm_mask = 4'hf;
                if (i_ribm_gnt) state_d = ST_WR_RSP;
            end
            ST_WR_RSP: begin
                o_ribm_rdy = 1'b1;
                if (i_ribm_rsp) begin
                    cur_src_d = cur_src_q + 32'd4;
                    cur_dst_d = cur_dst_q + 32'd4;
                    rem_d     = rem_q - LEN_W'(1);
                    state_d   = (rem_q == LEN_W'(1)) ? ST_FIN : ST_RD_REQ;
                end
            end
            ST_FIN: begin
                o_irq   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            buf_q     <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            buf_q     <= buf_d;
            rem_q     <= rem_d;
        end
    end

    assign o_ribm_wdata = buf_q;

endmodule

// File: tb/tb_rib_dma.sv
// Randomized bench for rib_dma: a RIB memory model with random gnt/rsp stalls
// records bus traffic, which is compared against the ideal copy sequence.
module tb_rib_dma;
    import rib_dma_pkg::*;

    logic        i_clk, i_rst;
    logic [31:0] i_ribs_addr, i_ribs_wdata, o_ribs_rdata;
    logic        i_ribs_wrcs, i_ribs_req, o_ribs_gnt, o_ribs_rsp, i_ribs_rdy;
    logic [3:0]  i_ribs_mask;
    logic [31:0] o_ribm_addr, o_ribm_wdata, i_ribm_rdata;
    logic        o_ribm_wrcs, o_ribm_req, i_ribm_gnt, i_ribm_rsp, o_ribm_rdy;
    logic [3:0]  o_ribm_mask;
    logic        o_irq;

    rib_dma #(.LEN_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_ribs_addr(i_ribs_addr), .i_ribs_wrcs(i_ribs_wrcs), .i_ribs_mask(i_ribs_mask),
        .i_ribs_wdata(i_ribs_wdata), .o_ribs_rdata(o_ribs_rdata), .i_ribs_req(i_ribs_req),
        .o_ribs_gnt(o_ribs_gnt), .o_ribs_rsp(o_ribs_rsp), .i_ribs_rdy(i_ribs_rdy),
        .o_ribm_addr(o_ribm_addr), .o_ribm_wrcs(o_ribm_wrcs), .o_ribm_mask(o_ribm_mask),
        .o_ribm_wdata(o_ribm_wdata), .i_ribm_rdata(i_ribm_rdata), .o_ribm_req(o_ribm_req),
        .i_ribm_gnt(i_ribm_gnt), .i_ribm_rsp(i_ribm_rsp), .o_ribm_rdy(o_ribm_rdy),
        .o_irq(o_irq)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;

    txn_t        trace[$];
    logic [31:0] mem [logic [31:0]];
    int          n_cmp = 0, n_err = 0;
    int          irq_cnt = 0, req_cyc = 0;
    int          mindly = 0, maxdly = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Initial memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    initial forever begin
        @(negedge i_clk);
        if (o_irq === 1'b1) irq_cnt++;
        if (o_ribm_req === 1'b1) req_cyc++;
    end

    // Memory model on the initiator port; decisions made at negedge take
    // effect on the following rising edge.
    initial begin
        logic [31:0] a, wd, rd;
        logic        w, abort;
        logic [3:0]  mk;
        int          d, n;
        i_ribm_gnt = 1'b0; i_ribm_rsp = 1'b0; i_ribm_rdata = '0;
        forever begin
            i_ribm_gnt = 1'b0;
            i_ribm_rsp = 1'b0;
            if (o_ribm_req !== 1'b1 || i_rst !== 1'b0) begin
                @(negedge i_clk);
                continue;
            end
            a = o_ribm_addr; w = o_ribm_wrcs; wd = o_ribm_wdata; mk = o_ribm_mask;
            rd = '0; abort = 1'b0;
            d = $urandom_range(maxdly, mindly);
            repeat (d) begin
                @(negedge i_clk);
                if (i_rst) begin abort = 1'b1; break; end
                chk("stall_req", 32'(o_ribm_req), 32'd1);
                chk("stall_addr", o_ribm_addr, a);
                chk("stall_ctl", {27'd0, o_ribm_wrcs, o_ribm_mask}, {27'd0, w, mk});
                chk("stall_wdata", o_ribm_wdata, wd);
            end
            if (abort) continue;
            i_ribm_gnt = 1'b1;
            if (w) begin
                mem[a] = wd;
                trace.push_back('{1'b1, a, wd});
            end else begin
                rd = mem.exists(a) ? mem[a] : memf(a);
                trace.push_back('{1'b0, a, rd});
            end
            @(negedge i_clk);
            i_ribm_gnt = 1'b0;
            if (i_rst) continue;
            d = $urandom_range(maxdly, mindly);
            repeat (d) begin
                @(negedge i_clk);
                if (i_rst) begin abort = 1'b1; break; end
            end
            if (abort) continue;
            i_ribm_rdata = rd;
            i_ribm_rsp = 1'b1;
            n = 0;
            while (o_ribm_rdy !== 1'b1 && n < 20 && !i_rst) begin
                @(negedge i_clk);
                n++;
            end
            if (i_rst) continue;
            chk("rsp_rdy", 32'(o_ribm_rdy), 32'd1);
            @(negedge i_clk);
        end
    end

    task automatic cfg_xact(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] mk, output logic [31:0] rd);
        int n;
        @(negedge i_clk);
        i_ribs_req = 1'b1; i_ribs_wrcs = wr; i_ribs_addr = a; i_ribs_wdata = wd; i_ribs_mask = mk;
        n = 0;
        #1;
        while (!o_ribs_gnt && n < 50) begin @(negedge i_clk); #1; n++; end
        chk("cfg_gnt", 32'(o_ribs_gnt), 32'd1);
        @(negedge i_clk);
        i_ribs_req = 1'b0; i_ribs_rdy = 1'b1;
        n = 0;
        #1;
        while (!o_ribs_rsp && n < 50) begin @(negedge i_clk); #1; n++; end
        chk("cfg_rsp", 32'(o_ribs_rsp), 32'd1);
        rd = o_ribs_rdata;
        @(negedge i_clk);
        i_ribs_rdy = 1'b0;
    endtask

    task automatic cfg_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] mk);
        logic [31:0] dummy;
        cfg_xact(1'b1, a, wd, mk, dummy);
    endtask

    task automatic cfg_rd(input logic [31:0] a, output logic [31:0] rd);
        cfg_xact(1'b0, a, '0, 4'hf, rd);
    endtask

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input int len,
                              input int mn, input int mx);
        mindly = mn; maxdly = mx;
        trace.delete();
        cfg_wr(32'(REG_SRC), s, 4'hf);
        cfg_wr(32'(REG_DST), d, 4'hf);
        cfg_wr(32'(REG_LEN), 32'(len), 4'hf);
        cfg_wr(32'(REG_CTRL), 32'h1, 4'hf);
    endtask

    // Waits for the completion pulse, then checks against the ideal copy:
    // word i is read from s+4i and its value written to d+4i, in that order.
    task automatic finish_xfer(input logic [31:0] s, input logic [31:0] d, input int len,
                               input int base_irq);
        int cyc;
        logic [31:0] v;
        cyc = 0;
        while (irq_cnt == base_irq && cyc < 5000) begin @(negedge i_clk); cyc++; end
        repeat (3) @(negedge i_clk);
        chk("irq_count", 32'(irq_cnt - base_irq), 32'd1);
        chk("trace_len", 32'(trace.size()), 32'(2 * len));
        for (int i = 0; i < len; i++) begin
            if (2 * i + 1 < trace.size()) begin
                chk("rd_addr", trace[2*i].a, s + 32'(4 * i));
                chk("rd_kind", 32'(trace[2*i].w), 32'd0);
                chk("wr_addr", trace[2*i+1].a, d + 32'(4 * i));
                chk("wr_kind", 32'(trace[2*i+1].w), 32'd1);
                chk("wr_data", trace[2*i+1].d, memf(s + 32'(4 * i)));
            end
        end
        cfg_rd(32'(REG_CTRL), v);
        chk("ctrl_done", v, 32'h4);
        cfg_rd(32'(REG_SRC), v);
        chk("src_kept", v, s);
        cfg_rd(32'(REG_LEN), v);
        chk("len_kept", v, 32'(len));
        cfg_wr(32'(REG_CTRL), 32'h4, 4'hf);
    endtask

    initial begin
        logic [31:0] v, s, d;
        int          base, len, cyc;
        i_rst = 1'b1;
        i_ribs_req = 1'b0; i_ribs_wrcs = 1'b0; i_ribs_addr = '0; i_ribs_wdata = '0;
        i_ribs_mask = '0; i_ribs_rdy = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_ribm_req", 32'(o_ribm_req), 32'd0);
        chk("rst_ribm_addr", o_ribm_addr, 32'd0);
        chk("rst_misc", {25'd0, o_ribm_mask, o_ribm_rdy, o_irq, o_ribs_rsp}, 32'd0);
        i_rst = 1'b0;
        cfg_rd(32'(REG_CTRL), v);
        chk("ctrl_reset", v, 32'd0);

        // Basic copy, zero-latency memory.
        base = irq_cnt;
        start_xfer(32'h100, 32'h200, 4, 0, 0);
        finish_xfer(32'h100, 32'h200, 4, base);
        cfg_rd(32'(REG_CTRL), v);
        chk("done_clear", v, 32'd0);

        // Random placements, lengths and bus stalls.
        for (int k = 0; k < 4; k++) begin
            s = 32'h1000_0000 | (32'($urandom_range(0, 4095)) << 2);
            d = 32'h2000_0000 | (32'($urandom_range(0, 4095)) << 2);
            len = $urandom_range(1, 6);
            base = irq_cnt;
            start_xfer(s, d, len, 0, 5);
            finish_xfer(s, d, len, base);
        end

        // Byte-masked register writes and unmapped offsets.
        cfg_wr(32'(REG_SRC), 32'hFFFF_FFFF, 4'hf);
        cfg_wr(32'(REG_SRC), 32'h1234_5678, 4'b0101);
        cfg_rd(32'(REG_SRC), v);
        chk("mask_src", v, 32'hFF34_FF78);
        cfg_wr(32'(REG_LEN), 32'h0001_0003, 4'hf);
        cfg_rd(32'(REG_LEN), v);
        chk("len_width", v, 32'h0000_0003);
        cfg_wr(32'h1, 32'hDEAD_BEEF, 4'hf);
        cfg_rd(32'h1, v);
        chk("unmapped", v, 32'd0);

        // Source address wraps past the top of memory.
        base = irq_cnt;
        start_xfer(32'hFFFF_FFFC, 32'h300, 2, 0, 3);
        finish_xfer(32'hFFFF_FFFC, 32'h300, 2, base);

        // Zero length: no bus traffic, completion two edges after START.
        base = irq_cnt;
        cyc = req_cyc;
        cfg_wr(32'(REG_LEN), 32'd0, 4'hf);
        cfg_wr(32'(REG_CTRL), 32'h1, 4'hf);
        chk("len0_irq", 32'(o_irq), 32'd1);
        repeat (3) @(negedge i_clk);
        chk("len0_irq_cnt", 32'(irq_cnt - base), 32'd1);
        chk("len0_no_req", 32'(req_cyc - cyc), 32'd0);
        cfg_rd(32'(REG_CTRL), v);
        chk("len0_done", v, 32'h4);
        cfg_wr(32'(REG_CTRL), 32'h4, 4'hf);

        // Reprogramming and restarting while busy are ignored.
        base = irq_cnt;
        start_xfer(32'h5000_0000, 32'h6000_0000, 5, 1, 5);
        repeat (4) @(negedge i_clk);
        cfg_rd(32'(REG_CTRL), v);
        chk("busy_bit", v, 32'h2);
        cfg_wr(32'(REG_LEN), 32'd9, 4'hf);
        cfg_wr(32'(REG_CTRL), 32'h1, 4'hf);
        finish_xfer(32'h5000_0000, 32'h6000_0000, 5, base);

        // Reset in the middle of a write request.
        base = irq_cnt;
        start_xfer(32'h7000_0000, 32'h7800_0000, 4, 3, 5);
        cyc = 0;
        while (!(o_ribm_req === 1'b1 && o_ribm_wrcs === 1'b1) && cyc < 2000) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("saw_wr_req", 32'(o_ribm_req & o_ribm_wrcs), 32'd1);
        #2 i_rst = 1'b1;
        #1;
        chk("rst_mid_req", {30'd0, o_ribm_req, o_ribm_wrcs}, 32'd0);
        chk("rst_mid_addr", o_ribm_addr, 32'd0);
        chk("rst_mid_wdata", o_ribm_wdata, 32'd0);
        chk("rst_mid_misc", {25'd0, o_ribm_mask, o_ribm_rdy, o_irq, o_ribs_rsp}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (10) @(negedge i_clk);
        chk("rst_no_irq", 32'(irq_cnt - base), 32'd0);
        cfg_rd(32'(REG_CTRL), v);
        chk("rst_ctrl", v, 32'd0);
        cfg_rd(32'(REG_SRC), v);
        chk("rst_src", v, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
